// File: rtl/avalon_dp_onchip_ram_if.sv
// ----------------------------------------------------------------------------
// avalon_dp_onchip_ram_if
// Bus bundle for the dual-port on-chip RAM.
//   s1_*  : Avalon-MM read/write slave port (byte enables, pipelined reads,
//           readdatavalid, waitrequest)
//   s2_*  : read-only sample-fetch port for the waveform sequencer
// Modports:
//   master : drives requests, receives read data (bus master / sequencer side)
//   slave  : receives requests, returns read data (RAM side)
// ----------------------------------------------------------------------------
interface avalon_dp_onchip_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0]   s1_address;
    logic                s1_chipselect;
    logic                s1_read;
    logic                s1_write;
    logic [DATA_W/8-1:0] s1_byteenable;
    logic [DATA_W-1:0]   s1_writedata;
    logic [DATA_W-1:0]   s1_readdata;
    logic                s1_readdatavalid;
    logic                s1_waitrequest;

    logic [ADDR_W-1:0]   s2_address;
    logic                s2_read;
    logic [DATA_W-1:0]   s2_readdata;
    logic                s2_readdatavalid;

    modport master (
        output s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
        input  s1_readdata, s1_readdatavalid, s1_waitrequest,
        output s2_address, s2_read,
        input  s2_readdata, s2_readdatavalid
    );

    modport slave (
        input  s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
        output s1_readdata, s1_readdatavalid, s1_waitrequest,
        input  s2_address, s2_read,
        output s2_readdata, s2_readdatavalid
    );
endinterface

// File: rtl/avalon_dp_onchip_ram.sv
// ----------------------------------------------------------------------------
// avalon_dp_onchip_ram
// Parametrised dual-port on-chip RAM for the PWM microcontroller system.
// s1 is an Avalon-MM read/write slave with byte enables and pipelined reads;
// s2 is a read-only port for the waveform sequencer. A built-in clear engine
// zeroes the whole array, one word per cycle, on request.
// Ports:
//   i_clk        : system clock
//   i_reset      : asynchronous reset, active-high (array contents are kept)
//   io_bus       : s1/s2 bus bundle (slave modport)
//   i_clear_req  : start the zero-fill of the whole array
//   o_clear_busy : high while the zero-fill runs
//   i_freeze     : blocks new accesses on both ports; in-flight reads drain
// ----------------------------------------------------------------------------
module avalon_dp_onchip_ram #(
    parameter int    DATA_W       = 32,
    parameter int    ADDR_W       = 10,
    parameter int    DEPTH        = 1024,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    avalon_dp_onchip_ram_if.slave io_bus,
    input  logic                  i_clear_req,
    output logic                  o_clear_busy,
    input  logic                  i_freeze
);
    localparam int NBYTES = DATA_W / 8;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_addr;

    logic              w_busy;
    logic              w_wait;
    logic              w_clr_we;
    logic              w_s1_in_range;
    logic              w_s2_in_range;
    logic              w_s1_wr_acc;
    logic              w_s1_rd_acc;
    logic              w_s2_rd_acc;
    logic [DATA_W-1:0] w_s1_word;
    logic [DATA_W-1:0] w_s2_word;

    assign w_busy        = (r_state == ST_CLEAR);
    assign w_wait        = i_freeze | w_busy;
    assign w_clr_we      = w_busy & ~i_freeze;
    assign o_clear_busy  = w_busy;
    assign io_bus.s1_waitrequest = w_wait;

    assign w_s1_in_range = 32'(io_bus.s1_address) < DEPTH;
    assign w_s2_in_range = 32'(io_bus.s2_address) < DEPTH;

    // A simultaneous read+write on s1 is treated as a write only.
    assign w_s1_wr_acc = io_bus.s1_chipselect & io_bus.s1_write & ~w_wait;
    assign w_s1_rd_acc = io_bus.s1_chipselect & io_bus.s1_read & ~io_bus.s1_write & ~w_wait;
    assign w_s2_rd_acc = io_bus.s2_read & ~w_wait;

    // Out-of-range reads return zero; reads see the array before this edge's write.
    assign w_s1_word = w_s1_in_range ? r_mem[io_bus.s1_address] : '0;
    assign w_s2_word = w_s2_in_range ? r_mem[io_bus.s2_address] : '0;

    // Array has no reset so contents survive reset and a clear aborted by it.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_s1_wr_acc && w_s1_in_range) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (io_bus.s1_byteenable[b]) begin
                    r_mem[io_bus.s1_address][b*8 +: 8] <= io_bus.s1_writedata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear_req) begin
                        r_state    <= ST_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                default: begin
                    if (!i_freeze) begin
                        if (r_clr_addr == LAST_ADDR) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_clr_addr <= r_clr_addr + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // First read stage; data registers load only on an accepted read so the
    // outputs hold their last value while valid is low.
    logic              r_s1_v0;
    logic              r_s2_v0;
    logic [DATA_W-1:0] r_s1_d0;
    logic [DATA_W-1:0] r_s2_d0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1_v0 <= 1'b0;
            r_s2_v0 <= 1'b0;
            r_s1_d0 <= '0;
            r_s2_d0 <= '0;
        end else begin
            r_s1_v0 <= w_s1_rd_acc;
            r_s2_v0 <= w_s2_rd_acc;
            if (w_s1_rd_acc) r_s1_d0 <= w_s1_word;
            if (w_s2_rd_acc) r_s2_d0 <= w_s2_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              r_s1_v1;
            logic              r_s2_v1;
            logic [DATA_W-1:0] r_s1_d1;
            logic [DATA_W-1:0] r_s2_d1;

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_s1_v1 <= 1'b0;
                    r_s2_v1 <= 1'b0;
                    r_s1_d1 <= '0;
                    r_s2_d1 <= '0;
                end else begin
                    r_s1_v1 <= r_s1_v0;
                    r_s2_v1 <= r_s2_v0;
                    if (r_s1_v0) r_s1_d1 <= r_s1_d0;
                    if (r_s2_v0) r_s2_d1 <= r_s2_d0;
                end
            end

            assign io_bus.s1_readdata      = r_s1_d1;
            assign io_bus.s1_readdatavalid = r_s1_v1;
            assign io_bus.s2_readdata      = r_s2_d1;
            assign io_bus.s2_readdatavalid = r_s2_v1;
        end else begin : g_lat1
            assign io_bus.s1_readdata      = r_s1_d0;
            assign io_bus.s1_readdatavalid = r_s1_v0;
            assign io_bus.s2_readdata      = r_s2_d0;
            assign io_bus.s2_readdatavalid = r_s2_v0;
        end
    endgenerate
endmodule

// File: tb/tb_avalon_dp_onchip_ram.sv
// ----------------------------------------------------------------------------
// tb_avalon_dp_onchip_ram
// Two RAM instances share one stimulus stream: dut_a with read latency 1 and
// dut_b with read latency 2. Stimulus updates a plain array model and pushes
// expected read results (data and due cycle) into per-stream queues; a
// negedge monitor pops and compares whenever a readdatavalid is seen.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_avalon_dp_onchip_ram;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_req = 1'b0;
    logic freeze = 1'b0;
    logic busy_a;
    logic busy_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // streams: 0 = a.s1, 1 = a.s2, 2 = b.s1, 3 = b.s2
    exp_t        sbq [4][$];
    logic [31:0] last_d [4];
    logic [31:0] model [0:DEPTH-1];

    avalon_dp_onchip_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    avalon_dp_onchip_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    assign bus_b.s1_address    = bus_a.s1_address;
    assign bus_b.s1_chipselect = bus_a.s1_chipselect;
    assign bus_b.s1_read       = bus_a.s1_read;
    assign bus_b.s1_write      = bus_a.s1_write;
    assign bus_b.s1_byteenable = bus_a.s1_byteenable;
    assign bus_b.s1_writedata  = bus_a.s1_writedata;
    assign bus_b.s2_address    = bus_a.s2_address;
    assign bus_b.s2_read       = bus_a.s2_read;

    avalon_dp_onchip_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut_a (
        .i_clk(clk), .i_reset(rst), .io_bus(bus_a),
        .i_clear_req(clear_req), .o_clear_busy(busy_a), .i_freeze(freeze)
    );

    avalon_dp_onchip_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .io_bus(bus_b),
        .i_clear_req(clear_req), .o_clear_busy(busy_b), .i_freeze(freeze)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void sb_pop(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        if (v) begin
            checks++;
            if (sbq[p].size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected stream %0d: got valid with %h, expected no valid (cycle %0d)", p, d, cyc);
                last_d[p] = d;
            end else begin
                e = sbq[p].pop_front();
                last_d[p] = e.data;
                if (d !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL rd_data stream %0d: got %h at cycle %0d, expected %h at cycle %0d",
                             p, d, cyc, e.data, e.due);
                end
            end
        end else begin
            checks++;
            if (d !== last_d[p]) begin
                errors++;
                $display("FAIL rd_hold stream %0d: got %h while not valid, expected held %h", p, d, last_d[p]);
            end
            if (sbq[p].size() != 0 && sbq[p][0].due <= cyc) begin
                e = sbq[p].pop_front();
                checks++;
                errors++;
                $display("FAIL rd_missing stream %0d: got no valid at cycle %0d, expected %h", p, cyc, e.data);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            sb_pop(0, bus_a.s1_readdatavalid, bus_a.s1_readdata);
            sb_pop(1, bus_a.s2_readdatavalid, bus_a.s2_readdata);
            sb_pop(2, bus_b.s1_readdatavalid, bus_b.s1_readdata);
            sb_pop(3, bus_b.s2_readdatavalid, bus_b.s2_readdata);
        end
    end

    function automatic void push(input int port, input logic [31:0] v);
        sbq[port].push_back('{data: v, due: cyc + 1});
        sbq[port + 2].push_back('{data: v, due: cyc + 2});
    endfunction

    // One bus cycle: apply inputs, predict the response, wait for the edge.
    task automatic step(input logic cs, input logic rd, input logic wr, input logic [4:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic s2r, input logic [4:0] a2, input logic frz);
        logic [31:0] mask;
        bus_a.s1_chipselect = cs;
        bus_a.s1_read       = rd;
        bus_a.s1_write      = wr;
        bus_a.s1_address    = a;
        bus_a.s1_byteenable = be;
        bus_a.s1_writedata  = wd;
        bus_a.s2_read       = s2r;
        bus_a.s2_address    = a2;
        freeze              = frz;
        if (cs && rd && !wr && !frz) push(0, (int'(a) < DEPTH) ? model[a[3:0]] : 32'h0);
        if (s2r && !frz) push(1, (int'(a2) < DEPTH) ? model[a2[3:0]] : 32'h0);
        if (cs && wr && !frz && int'(a) < DEPTH) begin
            mask = 32'h0;
            for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
            model[a[3:0]] = (model[a[3:0]] & ~mask) | (wd & mask);
        end
        #2;
        chk("waitrequest_a", {31'h0, bus_a.s1_waitrequest}, {31'h0, frz});
        chk("waitrequest_b", {31'h0, bus_b.s1_waitrequest}, {31'h0, frz});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic drain();
        repeat (4) idle();
    endtask

    // Runs one clear. freeze is held for frz_len cycles from busy count frz_from,
    // clear_req is re-pulsed at req_at (must be ignored), and reset is asserted
    // once rst_after busy cycles have been seen (0 = never).
    task automatic run_clear(input int frz_from, input int frz_len, input int req_at,
                             input int rst_after, input int exp_busy);
        int cnt;
        cnt = 0;
        bus_a.s1_chipselect = 1'b0;
        bus_a.s1_read       = 1'b0;
        bus_a.s1_write      = 1'b0;
        bus_a.s2_read       = 1'b0;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        while (busy_a && cnt < 100) begin
            cnt++;
            chk("clear_busy_b", {31'h0, busy_b}, 32'h1);
            chk("waitrequest_in_clear", {31'h0, bus_a.s1_waitrequest}, 32'h1);
            if (cnt == rst_after) begin
                rst = 1'b1;
                #1;
                chk("busy_after_reset_a", {31'h0, busy_a}, 32'h0);
                chk("busy_after_reset_b", {31'h0, busy_b}, 32'h0);
                chk("waitreq_after_reset", {31'h0, bus_a.s1_waitrequest}, 32'h0);
                for (int i = 0; i < rst_after - 1; i++) model[i] = 32'h0;
                for (int p = 0; p < 4; p++) last_d[p] = 32'h0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            freeze    = (cnt >= frz_from) && (cnt < frz_from + frz_len);
            clear_req = (cnt == req_at);
            @(posedge clk);
            #1;
        end
        freeze    = 1'b0;
        clear_req = 1'b0;
        chk("clear_busy_cycles", cnt, exp_busy);
        chk("clear_busy_b_done", {31'h0, busy_b}, 32'h0);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 1'b0, 5'(i), 4'h0, 32'h0, 1'b1, 5'(DEPTH - 1 - i), 1'b0);
        drain();
    endtask

    initial begin
        int op;
        logic rd;
        logic wr;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        for (int p = 0; p < 4; p++) last_d[p] = 32'h0;
        bus_a.s1_chipselect = 1'b0;
        bus_a.s1_read       = 1'b0;
        bus_a.s1_write      = 1'b0;
        bus_a.s1_address    = '0;
        bus_a.s1_byteenable = '0;
        bus_a.s1_writedata  = '0;
        bus_a.s2_read       = 1'b0;
        bus_a.s2_address    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s1_valid_a", {31'h0, bus_a.s1_readdatavalid}, 32'h0);
        chk("rst_s2_valid_a", {31'h0, bus_a.s2_readdatavalid}, 32'h0);
        chk("rst_s1_valid_b", {31'h0, bus_b.s1_readdatavalid}, 32'h0);
        chk("rst_s2_valid_b", {31'h0, bus_b.s2_readdatavalid}, 32'h0);
        chk("rst_s1_data_a", bus_a.s1_readdata, 32'h0);
        chk("rst_s2_data_b", bus_b.s2_readdata, 32'h0);
        chk("rst_busy_a", {31'h0, busy_a}, 32'h0);
        chk("rst_waitreq_a", {31'h0, bus_a.s1_waitrequest}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full clear with a 3-cycle freeze pause and an ignored clear_req: 16 + 3 busy cycles
        run_clear(4, 3, 8, 0, DEPTH + 3);
        read_all();

        // Full and partial byte-enable writes
        step(1'b1, 1'b0, 1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 5'd5, 4'h4, 32'h00AA0000, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);

        // Back-to-back reads of 0..3
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, 5'(i), 4'hF, $urandom, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 5'(i), 4'h0, 32'h0, 1'b0, 5'd0, 1'b0);

        // s2 read collides with s1 write: old data first, new data next
        step(1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h00001234, 1'b1, 5'd7, 1'b0);
        step(1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 1'b0);

        // Out of range: write dropped (no alias onto word 4), read returns 0
        step(1'b1, 1'b0, 1'b1, 5'd20, 4'hF, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5'd20, 4'h0, 32'h0, 1'b1, 5'd20, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5'd4, 4'h0, 32'h0, 1'b1, 5'd4, 1'b0);

        // Read then freeze: frozen requests give no valid, earlier read still returns
        step(1'b1, 1'b1, 1'b0, 5'd3, 4'h0, 32'h0, 1'b1, 5'd2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 5'd2, 4'h0, 32'h0, 1'b1, 5'd1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 5'd2, 4'hF, 32'h55555555, 1'b1, 5'd1, 1'b1);
        drain();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 5);
            rd = (op == 1) || (op == 3) || (op == 4) || (op == 0 && $urandom_range(0, 1) == 1);
            wr = (op == 2) || (op == 3) || (op == 5) || (op == 0 && $urandom_range(0, 1) == 1);
            step(op != 0, rd, wr, 5'($urandom_range(0, 19)), 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 19)), $urandom_range(0, 9) == 0);
        end
        drain();
        read_all();

        // Fill with known data, then reset in the middle of a clear
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 1'b1, 5'(i), 4'hF, $urandom, 1'b0, 5'd0, 1'b0);
        drain();
        run_clear(1000, 0, 1000, 9, 0);
        read_all();

        chk("scoreboard_empty", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
